// File: rtl/cpu_param.sv
// Multi-cycle parameterised core: FETCH -> EXEC -> (MEM) -> FETCH, with a halt state.
// Register file, datapath and data-memory bus are DATA_W wide; PC is always 32 bits.
module cpu_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_BUSYWAIT,
  input  logic              BUSYWAIT,
  output logic [31:0]       PC,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] READDATA,
  output logic              HALTED
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  localparam logic [7:0] OpLoadi = 8'h00;
  localparam logic [7:0] OpMov   = 8'h01;
  localparam logic [7:0] OpAdd   = 8'h02;
  localparam logic [7:0] OpSub   = 8'h03;
  localparam logic [7:0] OpAnd   = 8'h04;
  localparam logic [7:0] OpOr    = 8'h05;
  localparam logic [7:0] OpJ     = 8'h06;
  localparam logic [7:0] OpBeq   = 8'h07;
  localparam logic [7:0] OpLwd   = 8'h08;
  localparam logic [7:0] OpLwi   = 8'h09;
  localparam logic [7:0] OpSwd   = 8'h0A;
  localparam logic [7:0] OpSwi   = 8'h0B;
  localparam logic [7:0] OpBne   = 8'h0C;
  localparam logic [7:0] OpHalt  = 8'hFF;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   rf_q [NumRegs];
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  logic [7:0]          op;
  logic [REG_AW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]   rd_val, rs1_val, rs2_val, imm_ext, alu_res;
  logic [31:0]         br_off, pc_plus4;
  logic                is_alu, is_load, is_store, br_taken;
  logic                unused_ir;

  assign op       = ir_q[31:24];
  assign rd_idx   = ir_q[16 +: REG_AW];
  assign rs1_idx  = ir_q[8 +: REG_AW];
  assign rs2_idx  = ir_q[0 +: REG_AW];
  assign rd_val   = rf_q[rd_idx];
  assign rs1_val  = rf_q[rs1_idx];
  assign rs2_val  = rf_q[rs2_idx];
  assign imm_ext  = DATA_W'($signed(ir_q[7:0]));
  assign br_off   = {{22{ir_q[23]}}, ir_q[23:16], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;
  assign is_alu   = (op <= OpOr);
  assign is_load  = (op == OpLwd) || (op == OpLwi);
  assign is_store = (op == OpSwd) || (op == OpSwi);
  // Upper bits of the rs1 field are ignored when REG_AW < 8.
  assign unused_ir = ^ir_q[15:8];

  always_comb begin
    alu_res = '0;
    case (op)
      OpLoadi: alu_res = imm_ext;
      OpMov:   alu_res = rs1_val;
      OpAdd:   alu_res = rs1_val + rs2_val;
      OpSub:   alu_res = rs1_val - rs2_val;
      OpAnd:   alu_res = rs1_val & rs2_val;
      OpOr:    alu_res = rs1_val | rs2_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op)
      OpJ:     br_taken = 1'b1;
      OpBeq:   br_taken = (rs1_val == rs2_val);
      OpBne:   br_taken = (rs1_val != rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    unique case (state_q)
      StFetch: begin
        if (!INSTR_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_load || is_store) begin
          state_d = StMem;
        end else if (op == OpHalt) begin
          state_d = StHalt;
        end else begin
          // Unknown opcodes fall through here as NOPs: no write, PC+4.
          rf_we   = is_alu;
          pc_d    = br_taken ? pc_plus4 + br_off : pc_plus4;
          state_d = StFetch;
        end
      end
      StMem: begin
        if (!BUSYWAIT) begin
          rf_we    = is_load;
          rf_wdata = READDATA;
          pc_d     = pc_plus4;
          state_d  = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= '0;
      ir_q <= '0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (rf_we) begin
        rf_q[rd_idx] <= rf_wdata;
      end
    end
  end

  // Address and store data come straight from IR and the register file, both frozen in MEM.
  always_comb begin
    PC        = pc_q;
    READ      = (state_q == StMem) && is_load;
    WRITE     = (state_q == StMem) && is_store;
    HALTED    = (state_q == StHalt);
    ADDRESS   = ((op == OpLwd) || (op == OpSwd)) ? rs2_val : imm_ext;
    WRITEDATA = rd_val;
  end

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: ALU vector table, branch/stall/reset sequences,
// and a store scoreboard that compares every completed store against expectations.
module tb_cpu_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, rst16_n, ibw;
  logic [31:0] imem [64];
  logic [7:0]  dmem [256];
  int          stall_set, acc_cyc;
  int          n_vec, n_miss;

  // 8-bit core
  logic [31:0] pc, instr;
  logic        rd, wr, bw, halted;
  logic [7:0]  addr, wdata, rdata;

  assign instr = imem[pc[7:2]];
  assign rdata = dmem[addr];
  assign bw    = (rd | wr) && (acc_cyc < stall_set);

  always @(posedge CLK or negedge RESET) begin
    if (!RESET)        acc_cyc <= 0;
    else if (rd | wr)  acc_cyc <= acc_cyc + 1;
    else               acc_cyc <= 0;
  end

  cpu_param #(.DATA_W(8), .REG_AW(3)) u_dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr), .INSTR_BUSYWAIT(ibw), .BUSYWAIT(bw),
    .PC(pc), .READ(rd), .WRITE(wr), .ADDRESS(addr), .WRITEDATA(wdata), .READDATA(rdata),
    .HALTED(halted)
  );

  // 16-bit core, zero-wait data memory
  logic [31:0] pc16, instr16;
  logic        rd16, wr16, halted16;
  logic [15:0] addr16, wdata16;

  assign instr16 = imem[pc16[7:2]];

  cpu_param #(.DATA_W(16), .REG_AW(4)) u_dut16 (
    .CLK(CLK), .RESET(rst16_n), .INSTRUCTION(instr16), .INSTR_BUSYWAIT(1'b0), .BUSYWAIT(1'b0),
    .PC(pc16), .READ(rd16), .WRITE(wr16), .ADDRESS(addr16), .WRITEDATA(wdata16),
    .READDATA(16'h0000), .HALTED(halted16)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } st_t;
  st_t q8[$];
  st_t q16[$];

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] rdf;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A store completes on the edge following a negedge that sees WRITE=1 and BUSYWAIT=0.
  always @(negedge CLK) begin
    if (RESET && wr && !bw) begin
      if (q8.size() == 0) begin
        chk("store8_unexpected", {31'b0, wr}, 32'd0);
      end else begin
        st_t e;
        e = q8.pop_front();
        chk("store8_addr", {24'b0, addr}, {16'b0, e.addr});
        chk("store8_data", {24'b0, wdata}, {16'b0, e.data});
      end
    end
    if (rst16_n && wr16) begin
      if (q16.size() == 0) begin
        chk("store16_unexpected", {31'b0, wr16}, 32'd0);
      end else begin
        st_t e;
        e = q16.pop_front();
        chk("store16_addr", {16'b0, addr16}, {16'b0, e.addr});
        chk("store16_data", {16'b0, wdata16}, {16'b0, e.data});
      end
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] o, input logic [7:0] f1,
                                      input logic [7:0] f2, input logic [7:0] f3);
    return {o, f1, f2, f3};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_reset();
    RESET = 1'b0;
    ibw = 1'b0;
    stall_set = 0;
    tick();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic wait_halt(input int max);
    for (int i = 0; i < max && !halted; i++) tick();
    chk("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  task automatic drain();
    chk("sb_drain", 32'(q8.size()), 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    rst16_n = 1'b0;
    ibw = 1'b0;
    stall_set = 0;
    n_vec = 0;
    n_miss = 0;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    for (int i = 0; i < 256; i++) dmem[i] = 8'(i) ^ 8'h5A;
    dmem[8'h20] = 8'hAB;

    //            op     rd     a      b      expected
    vecs[0]  = '{8'h02, 8'd3, 8'h05, 8'hFD, 8'h02};
    vecs[1]  = '{8'h03, 8'd3, 8'hFD, 8'h05, 8'hF8};
    vecs[2]  = '{8'h03, 8'd3, 8'h00, 8'h01, 8'hFF};
    vecs[3]  = '{8'h04, 8'd3, 8'hF0, 8'h3C, 8'h30};
    vecs[4]  = '{8'h05, 8'd3, 8'hF0, 8'h0F, 8'hFF};
    vecs[5]  = '{8'h02, 8'd3, 8'h80, 8'h80, 8'h00};
    vecs[6]  = '{8'h01, 8'd3, 8'h5A, 8'h11, 8'h5A};
    vecs[7]  = '{8'h02, 8'd1, 8'h10, 8'h22, 8'h32};
    vecs[8]  = '{8'h03, 8'd0, 8'h09, 8'h03, 8'h06};
    vecs[9]  = '{8'h42, 8'd3, 8'h07, 8'h08, 8'h00};
    vecs[10] = '{8'h0D, 8'd1, 8'h07, 8'h08, 8'h07};

    ticks(2);
    chk("rst_pc", pc, 32'd0);
    chk("rst_read", {31'b0, rd}, 32'd0);
    chk("rst_write", {31'b0, wr}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // ALU table: loadi r1,a; loadi r2,b; op rd,r1,r2; swi rd,0x40; halt
    for (int i = 0; i < 11; i++) begin
      hold_reset();
      imem[0] = ins(8'h00, 8'd1, 8'd0, vecs[i].a);
      imem[1] = ins(8'h00, 8'd2, 8'd0, vecs[i].b);
      imem[2] = ins(vecs[i].op, vecs[i].rdf, 8'd1, 8'd2);
      imem[3] = ins(8'h0B, vecs[i].rdf, 8'd0, 8'h40);
      q8.push_back('{addr: 16'h0040, data: {8'h00, vecs[i].exp}});
      release_reset();
      wait_halt(40);
      chk("vec_pc", pc, 32'd16);
      drain();
    end

    // Arithmetic timing plus halt hold
    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h05);
    imem[1] = ins(8'h00, 8'd2, 8'd0, 8'hFD);
    imem[2] = ins(8'h02, 8'd3, 8'd1, 8'd2);
    imem[3] = ins(8'h03, 8'd4, 8'd2, 8'd1);
    imem[4] = ins(8'h0B, 8'd3, 8'd0, 8'h10);
    imem[5] = ins(8'h0B, 8'd4, 8'd0, 8'h11);
    q8.push_back('{addr: 16'h0010, data: 16'h0002});
    q8.push_back('{addr: 16'h0011, data: 16'h00F8});
    release_reset();
    ticks(8);
    chk("arith_pc_8cyc", pc, 32'd16);
    wait_halt(40);
    chk("halt_pc", pc, 32'd24);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold_pc", pc, 32'd24);
      chk("halt_no_strobe", {31'b0, rd | wr}, 32'd0);
    end
    drain();

    // Branches, each with a nop or loadi ahead so the branch sits at PC=8
    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h07);
    imem[1] = ins(8'h42, 8'd0, 8'd0, 8'd0);
    imem[2] = ins(8'h07, 8'hFE, 8'd1, 8'd1);
    release_reset();
    ticks(6);
    chk("beq_taken_pc", pc, 32'd4);

    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h07);
    imem[1] = ins(8'h42, 8'd0, 8'd0, 8'd0);
    imem[2] = ins(8'h0C, 8'h05, 8'd1, 8'd1);
    release_reset();
    ticks(6);
    chk("bne_equal_pc", pc, 32'd12);

    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h07);
    imem[1] = ins(8'h00, 8'd2, 8'd0, 8'h08);
    imem[2] = ins(8'h0C, 8'h03, 8'd1, 8'd2);
    release_reset();
    ticks(6);
    chk("bne_taken_pc", pc, 32'd24);

    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h07);
    imem[1] = ins(8'h00, 8'd2, 8'd0, 8'h08);
    imem[2] = ins(8'h07, 8'h03, 8'd1, 8'd2);
    release_reset();
    ticks(6);
    chk("beq_not_taken_pc", pc, 32'd12);

    hold_reset();
    imem[0] = ins(8'h06, 8'h7F, 8'd0, 8'd0);
    release_reset();
    ticks(2);
    chk("j_fwd_pc", pc, 32'h0000_0200);

    hold_reset();
    imem[0] = ins(8'h06, 8'h80, 8'd0, 8'd0);
    release_reset();
    ticks(2);
    chk("j_wrap_pc", pc, 32'hFFFF_FE04);

    // Load with three stall cycles
    hold_reset();
    imem[0] = ins(8'h09, 8'd5, 8'd0, 8'h20);
    imem[1] = ins(8'h0B, 8'd5, 8'd0, 8'h41);
    stall_set = 3;
    q8.push_back('{addr: 16'h0041, data: 16'h00AB});
    release_reset();
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      chk("ld_read", {31'b0, rd}, 32'd1);
      chk("ld_addr", {24'b0, addr}, 32'h20);
      chk("ld_pc_frozen", pc, 32'd0);
      tick();
    end
    chk("ld_read_drop", {31'b0, rd}, 32'd0);
    chk("ld_pc", pc, 32'd4);
    wait_halt(40);
    drain();

    // Store interrupted by reset mid-MEM
    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h11);
    imem[1] = ins(8'h00, 8'd2, 8'd0, 8'h30);
    imem[2] = ins(8'h0A, 8'd1, 8'd0, 8'd2);
    stall_set = 5;
    release_reset();
    ticks(6);
    chk("st_write", {31'b0, wr}, 32'd1);
    chk("st_read_low", {31'b0, rd}, 32'd0);
    chk("st_addr", {24'b0, addr}, 32'h30);
    chk("st_wdata", {24'b0, wdata}, 32'h11);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_rst_write", {31'b0, wr}, 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    drain();

    // Same store allowed to complete
    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h11);
    imem[1] = ins(8'h00, 8'd2, 8'd0, 8'h30);
    imem[2] = ins(8'h0A, 8'd1, 8'd0, 8'd2);
    q8.push_back('{addr: 16'h0030, data: 16'h0011});
    release_reset();
    wait_halt(40);
    chk("swd_halt_pc", pc, 32'd12);
    drain();

    // Instruction-memory stall freezes PC, both after reset and mid-program
    hold_reset();
    imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h33);
    imem[1] = ins(8'h0B, 8'd1, 8'd0, 8'h42);
    q8.push_back('{addr: 16'h0042, data: 16'h0033});
    ibw = 1'b1;
    release_reset();
    ticks(3);
    chk("ibw_first_fetch_pc", pc, 32'd0);
    ibw = 1'b0;
    ticks(2);
    chk("ibw_after_pc", pc, 32'd4);
    ibw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ibw_pc_frozen", pc, 32'd4);
    end
    ibw = 1'b0;
    wait_halt(40);
    chk("ibw_halt_pc", pc, 32'd8);
    drain();

    // Width test on both instances: loadi r15,0x80; add r15,r15,r15; swi r15,0x40
    hold_reset();
    rst16_n = 1'b0;
    imem[0] = ins(8'h00, 8'h0F, 8'd0, 8'h80);
    imem[1] = ins(8'h02, 8'h0F, 8'h0F, 8'h0F);
    imem[2] = ins(8'h0B, 8'h0F, 8'd0, 8'h40);
    q8.push_back('{addr: 16'h0040, data: 16'h0000});
    q16.push_back('{addr: 16'h0040, data: 16'hFF00});
    @(negedge CLK);
    RESET = 1'b1;
    rst16_n = 1'b1;
    wait_halt(40);
    for (int i = 0; i < 40 && !halted16; i++) tick();
    chk("w16_halted", {31'b0, halted16}, 32'd1);
    chk("w16_pc", pc16, 32'd12);
    chk("w16_read", {31'b0, rd16}, 32'd0);
    chk("w16_drain", 32'(q16.size()), 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
